// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request-side controller: FSM state
// encoding and the fill value written by the clear sweep.
package ram_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_CAP,
    CLR
  } state_t;

  // Fill pattern for the clear sweep, sized down to the RAM word at use
  localparam logic [63:0] CLR_FILL = '0;

endpackage

// File: rtl/ram_access_ctrl.sv
// Request-side controller for a single-port synchronous RAM with a
// registered 1-cycle read port. Serialises read/write requests onto the
// RAM pins, returns read data over a valid/ready response channel, and
// offers a zero-fill sweep over every RAM location.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request or clear_start; RAM enables low
// WR     | ram_write_en high for the single cycle of the write
// RD     | ram_read_en high; RAM registers its data at the exit edge
// RD_CAP | RAM data valid; captured into rsp_rdata at the exit edge
// CLR    | sweep writing CLR_FILL to addresses 0..MAX_MEM_LOC
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_BUS_WIDTH = 4,
  parameter int MAX_MEM_LOC    = 2**ADDR_BUS_WIDTH-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      ram_read_en,
  output logic                      ram_write_en,
  output logic [ADDR_BUS_WIDTH-1:0] ram_address_loc,
  output logic [DATA_WIDTH-1:0]     ram_data_in,
  input  logic [DATA_WIDTH-1:0]     ram_data_out
);

  // Sweep ends on a compare, so a RAM smaller than the address space works
  localparam logic [ADDR_BUS_WIDTH-1:0] LP_LAST_ADDR = ADDR_BUS_WIDTH'(MAX_MEM_LOC);

  state_t                    r_state;
  logic                      r_rsp_valid;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                      r_clear_busy;
  logic                      r_clear_done;
  logic                      r_ram_read_en;
  logic                      r_ram_write_en;
  logic [ADDR_BUS_WIDTH-1:0] r_ram_address_loc;
  logic [DATA_WIDTH-1:0]     r_ram_data_in;
  logic [ADDR_BUS_WIDTH-1:0] r_sweep_addr;

  logic w_rsp_stall;
  logic w_req_ready;
  logic w_req_fire;

  // A pending, unconsumed response blocks new requests so it is never overwritten;
  // clear_start takes priority over a simultaneous request.
  assign w_rsp_stall = r_rsp_valid && !rsp_ready;
  assign w_req_ready = (r_state == IDLE) && !clear_start && !w_rsp_stall;
  assign w_req_fire  = req_valid && w_req_ready;

  // FSM with registered RAM-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_rsp_valid       <= 1'b0;
      r_rsp_rdata       <= '0;
      r_clear_busy      <= 1'b0;
      r_clear_done      <= 1'b0;
      r_ram_read_en     <= 1'b0;
      r_ram_write_en    <= 1'b0;
      r_ram_address_loc <= '0;
      r_ram_data_in     <= '0;
      r_sweep_addr      <= '0;
    end else begin
      r_clear_done <= 1'b0;
      if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (clear_start) begin
            r_state           <= CLR;
            r_sweep_addr      <= '0;
            r_ram_address_loc <= '0;
            r_ram_data_in     <= DATA_WIDTH'(CLR_FILL);
            r_ram_write_en    <= 1'b1;
            r_clear_busy      <= 1'b1;
          end else if (w_req_fire) begin
            r_ram_address_loc <= req_addr;
            if (req_write) begin
              r_state        <= WR;
              r_ram_write_en <= 1'b1;
              r_ram_data_in  <= req_wdata;
            end else begin
              r_state       <= RD;
              r_ram_read_en <= 1'b1;
            end
          end
        end
        WR: begin
          r_ram_write_en <= 1'b0;
          r_state        <= IDLE;
        end
        RD: begin
          r_ram_read_en <= 1'b0;
          r_state       <= RD_CAP;
        end
        RD_CAP: begin
          // ram_data_out is only trusted on this edge
          r_rsp_rdata <= ram_data_out;
          r_rsp_valid <= 1'b1;
          r_state     <= IDLE;
        end
        CLR: begin
          if (r_sweep_addr < LP_LAST_ADDR) begin
            r_sweep_addr      <= r_sweep_addr + 1'b1;
            r_ram_address_loc <= r_sweep_addr + 1'b1;
          end else begin
            r_ram_write_en <= 1'b0;
            r_clear_busy   <= 1'b0;
            r_clear_done   <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_ram_read_en  <= 1'b0;
          r_ram_write_en <= 1'b0;
          r_clear_busy   <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = w_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign clear_busy      = r_clear_busy;
  assign clear_done      = r_clear_done;
  assign ram_read_en     = r_ram_read_en;
  assign ram_write_en    = r_ram_write_en;
  assign ram_address_loc = r_ram_address_loc;
  assign ram_data_in     = r_ram_data_in;

endmodule
